// File: rtl/bb_pwm_out_if.sv
// bb_pwm_out_if: PID-stage command strobe into the PWM stage, ESC pulse and
// status back out. The PID stage is the master, bb_pwm_out is the slave.
interface bb_pwm_out_if;
    logic        to_pwm_oe;
    logic [15:0] to_pwm;
    logic        pwm_out;
    logic        armed;
    logic        period_start;
    logic        cmd_ack;
    logic        failsafe;

    modport master (
        output to_pwm_oe,
        output to_pwm,
        input  pwm_out,
        input  armed,
        input  period_start,
        input  cmd_ack,
        input  failsafe
    );

    modport slave (
        input  to_pwm_oe,
        input  to_pwm,
        output pwm_out,
        output armed,
        output period_start,
        output cmd_ack,
        output failsafe
    );
endinterface

// File: rtl/bb_pwm_out.sv
// bb_pwm_out: fixed-frequency ESC servo pulse generator for one motor.
// Commands are double-buffered (shadow -> active at the period wrap), an
// arming sequence of ARM_PERIODS minimum-width periods runs after reset, and
// period_start paces the upstream PID loop.
// Optional feature macro: BB_PWM_FAILSAFE_EN adds a command watchdog that
// drops the output to MIN_TICKS after WDT_PERIODS silent periods.
module bb_pwm_out #(
    parameter int unsigned PERIOD_TICKS = 125000,
    parameter int unsigned MIN_TICKS    = 50000,
    parameter int unsigned MAX_TICKS    = 100000,
    parameter int unsigned ARM_PERIODS  = 200,
    parameter int unsigned CNT_W        = 17,
    parameter int unsigned WDT_PERIODS  = 20
) (
    input  logic        clk,
    input  logic        rst,
    bb_pwm_out_if.slave bus
);

    localparam int unsigned W_W   = CNT_W + 1;
    localparam int unsigned ARM_W = (ARM_PERIODS > 1) ? $clog2(ARM_PERIODS) : 1;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PERIOD_TICKS - 1);
    localparam logic [W_W-1:0]   MIN_W    = W_W'(MIN_TICKS);
    localparam logic [W_W-1:0]   MAX_W    = W_W'(MAX_TICKS);
    localparam logic [ARM_W-1:0] ARM_LAST = ARM_W'(ARM_PERIODS - 1);
    // Largest command that does not saturate; clamped so a span beyond 16
    // bits simply means no 16-bit command can saturate.
    localparam logic [15:0]      SPAN     = ((MAX_TICKS - MIN_TICKS) > 32'd65535) ?
                                            16'hFFFF : 16'(MAX_TICKS - MIN_TICKS);

    // Reject configurations that would break the every-period-has-a-pulse rule.
    if (PERIOD_TICKS < 2 || PERIOD_TICKS > (32'd1 << CNT_W) || MIN_TICKS == 0 ||
        MIN_TICKS > MAX_TICKS || MAX_TICKS >= PERIOD_TICKS || ARM_PERIODS == 0 ||
        WDT_PERIODS == 0) begin : g_cfg_err
        $error("bb_pwm_out: illegal parameter set");
    end

    typedef enum logic [0:0] {
        ST_ARM = 1'b0,
        ST_RUN = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [W_W-1:0]   shadow_q, shadow_d;
    logic [W_W-1:0]   active_q, active_d;
    logic [ARM_W-1:0] arm_q, arm_d;
    logic             pwm_q, pwm_d;
    logic             armed_q, armed_d;
    logic             ps_q, ps_d;
    logic             ack_q, ack_d;

    logic             wrap_c;
    logic             accept_c;
    logic [W_W-1:0]   width_c;

`ifdef BB_PWM_FAILSAFE_EN
    localparam int unsigned WDT_W = $clog2(WDT_PERIODS + 1);
    localparam logic [WDT_W-1:0] WDT_MAX  = WDT_W'(WDT_PERIODS);
    localparam logic [WDT_W-1:0] WDT_TRIP = WDT_W'(WDT_PERIODS - 1);

    logic [WDT_W-1:0] wdt_q, wdt_d;
    logic             seen_q, seen_d;
    logic             fs_q, fs_d;
`endif

    // Command-to-width mapping, saturating at MAX_TICKS without wrap.
    always_comb begin
        width_c = MAX_W;
        if (bus.to_pwm <= SPAN) begin
            width_c = MIN_W + W_W'(bus.to_pwm);
        end
    end

    assign wrap_c   = (cnt_q == CNT_LAST);
    assign accept_c = bus.to_pwm_oe && (state_q == ST_RUN);

    // Next-state logic: period counter, buffers, arming FSM and output decode.
    always_comb begin
        state_d  = state_q;
        cnt_d    = wrap_c ? '0 : cnt_q + CNT_W'(1);
        shadow_d = shadow_q;
        active_d = active_q;
        arm_d    = arm_q;
        armed_d  = armed_q;
        ps_d     = (cnt_q == '0);
        pwm_d    = ({1'b0, cnt_q} < active_q);
        ack_d    = accept_c;
`ifdef BB_PWM_FAILSAFE_EN
        wdt_d    = wdt_q;
        seen_d   = seen_q;
        fs_d     = fs_q;
`endif

        case (state_q)
            ST_ARM: begin
                shadow_d = MIN_W;
                active_d = MIN_W;
                if (wrap_c) begin
                    if (arm_q == ARM_LAST) begin
                        state_d = ST_RUN;
                        armed_d = 1'b1;
                    end else begin
                        arm_d = arm_q + ARM_W'(1);
                    end
                end
            end

            ST_RUN: begin
                if (accept_c) begin
                    shadow_d = width_c;
                end
                // A strobe in the wrap cycle goes straight to the new period.
                if (wrap_c) begin
                    active_d = accept_c ? width_c : shadow_q;
                end
`ifdef BB_PWM_FAILSAFE_EN
                // Count full periods that contained no command.
                if (accept_c) begin
                    fs_d   = 1'b0;
                    seen_d = !wrap_c;
                end else if (wrap_c) begin
                    seen_d = 1'b0;
                end
                if (wrap_c) begin
                    if (accept_c || seen_q) begin
                        wdt_d = '0;
                    end else begin
                        if (wdt_q != WDT_MAX) begin
                            wdt_d = wdt_q + WDT_W'(1);
                        end
                        if (wdt_q >= WDT_TRIP) begin
                            shadow_d = MIN_W;
                            active_d = MIN_W;
                            fs_d     = 1'b1;
                        end
                    end
                end
`endif
            end

            default: begin
                state_d = ST_ARM;
            end
        endcase
    end

    // State and output registers; reset truncates any pulse in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_ARM;
            cnt_q    <= '0;
            shadow_q <= MIN_W;
            active_q <= MIN_W;
            arm_q    <= '0;
            pwm_q    <= 1'b0;
            armed_q  <= 1'b0;
            ps_q     <= 1'b0;
            ack_q    <= 1'b0;
`ifdef BB_PWM_FAILSAFE_EN
            wdt_q    <= '0;
            seen_q   <= 1'b0;
            fs_q     <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            shadow_q <= shadow_d;
            active_q <= active_d;
            arm_q    <= arm_d;
            pwm_q    <= pwm_d;
            armed_q  <= armed_d;
            ps_q     <= ps_d;
            ack_q    <= ack_d;
`ifdef BB_PWM_FAILSAFE_EN
            wdt_q    <= wdt_d;
            seen_q   <= seen_d;
            fs_q     <= fs_d;
`endif
        end
    end

    assign bus.pwm_out      = pwm_q;
    assign bus.armed        = armed_q;
    assign bus.period_start = ps_q;
    assign bus.cmd_ack      = ack_q;
`ifdef BB_PWM_FAILSAFE_EN
    assign bus.failsafe     = fs_q;
`else
    assign bus.failsafe     = 1'b0;
`endif

endmodule

// File: tb/tb_bb_pwm_out.sv
// tb_bb_pwm_out: table-driven, hand-written and randomized checks of
// bb_pwm_out against a period-level behavioural model.
module tb_bb_pwm_out;

    localparam int PER  = 100;
    localparam int MINT = 20;
    localparam int MAXT = 60;
    localparam int ARMP = 2;
    localparam int WDTP = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;

    bb_pwm_out_if bus ();

    bb_pwm_out #(
        .PERIOD_TICKS(PER),
        .MIN_TICKS   (MINT),
        .MAX_TICKS   (MAXT),
        .ARM_PERIODS (ARMP),
        .CNT_W       (7),
        .WDT_PERIODS (WDTP)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Period-level reference model state.
    int m_per;
    int m_cur;
    int m_pend;
    int m_silent;
    bit m_fs;

    typedef struct {
        int          sa;
        logic [15:0] va;
        int          sb;
        logic [15:0] vb;
        int          e_hi;
        bit          e_armed;
        int          e_acks;
    } vec_t;

    vec_t tbl [11];

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int map_w(input int v);
        return (MINT + v > MAXT) ? MAXT : MINT + v;
    endfunction

    task automatic model_reset();
        m_per    = 0;
        m_cur    = MINT;
        m_pend   = MINT;
        m_silent = 0;
        m_fs     = 1'b0;
    endtask

    // Expected results for one period, then advance to the next period.
    task automatic model_period(input int sa, input logic [15:0] va, input int sb,
                                input logic [15:0] vb, output int e_hi, output bit e_armed,
                                output int e_acks, output bit e_fs);
        bit run;
        bit seen;
        int n;
        int last_v;
        run     = (m_per >= ARMP);
        e_hi    = m_cur;
        e_armed = run;
        e_fs    = m_fs;
        n = 0;
        if (sa >= 0) n++;
        if (sb >= 0) n++;
        e_acks = run ? n : 0;
        seen   = run && (n > 0);
        if (seen) begin
            if (sa >= 0 && (sb < 0 || sa > sb)) last_v = int'(va);
            else last_v = int'(vb);
            m_pend = map_w(last_v);
            m_fs   = 1'b0;
        end
        m_per++;
        m_cur = m_pend;
`ifdef BB_PWM_FAILSAFE_EN
        if (run) begin
            if (seen) begin
                m_silent = 0;
            end else begin
                m_silent++;
                if (m_silent >= WDTP) begin
                    m_pend = MINT;
                    m_cur  = MINT;
                    m_fs   = 1'b1;
                end
            end
        end
`endif
    endtask

    // Run one output period starting at the period_start sample; strobes at
    // counter positions sa/sb (-1 = none).
    task automatic run_period(input int sa, input logic [15:0] va, input int sb,
                              input logic [15:0] vb, input int e_hi, input bit e_armed,
                              input int e_acks, input bit e_fs, input string tag);
        int hi      = 0;
        int acks    = 0;
        int ps_err  = 0;
        int ack_err = 0;
        bit prev_acc = 1'b0;
        check({tag, " armed"}, int'(bus.armed), int'(e_armed));
        check({tag, " failsafe"}, int'(bus.failsafe), int'(e_fs));
        for (int p = 0; p < PER; p++) begin
            hi   += int'(bus.pwm_out);
            acks += int'(bus.cmd_ack);
            if (bus.period_start !== (p == 0)) ps_err++;
            if (bus.cmd_ack !== prev_acc) ack_err++;
            if (p + 1 == sa) begin
                bus.to_pwm_oe = 1'b1;
                bus.to_pwm    = va;
            end else if (p + 1 == sb) begin
                bus.to_pwm_oe = 1'b1;
                bus.to_pwm    = vb;
            end else begin
                bus.to_pwm_oe = 1'b0;
                bus.to_pwm    = 16'($urandom);
            end
            prev_acc = bus.to_pwm_oe && e_armed;
            step();
        end
        bus.to_pwm_oe = 1'b0;
        check({tag, " high_ticks"}, hi, e_hi);
        check({tag, " acks"}, acks, e_acks);
        check({tag, " period_start_timing"}, ps_err, 0);
        check({tag, " ack_timing"}, ack_err, 0);
    endtask

    task automatic model_run(input int sa, input logic [15:0] va, input int sb,
                             input logic [15:0] vb, input string tag);
        int e_hi;
        bit e_armed;
        int e_acks;
        bit e_fs;
        model_period(sa, va, sb, vb, e_hi, e_armed, e_acks, e_fs);
        run_period(sa, va, sb, vb, e_hi, e_armed, e_acks, e_fs, tag);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got time %0t expected completion", $time);
        $fatal(1, "timeout");
    end

    initial begin
        int sa;
        int sb;
        int k;
        logic [15:0] va;
        logic [15:0] vb;

        tbl[0]  = '{50, 16'd30,    -1, 16'd0,  20, 1'b0, 0};
        tbl[1]  = '{99, 16'd30,    -1, 16'd0,  20, 1'b0, 0};
        tbl[2]  = '{50, 16'd15,    -1, 16'd0,  20, 1'b1, 1};
        tbl[3]  = '{-1, 16'd0,     -1, 16'd0,  35, 1'b1, 0};
        tbl[4]  = '{40, 16'd100,   -1, 16'd0,  35, 1'b1, 1};
        tbl[5]  = '{40, 16'hFFFF,  -1, 16'd0,  60, 1'b1, 1};
        tbl[6]  = '{30, 16'd10,    70, 16'd30, 60, 1'b1, 2};
        tbl[7]  = '{99, 16'd5,     -1, 16'd0,  50, 1'b1, 1};
        tbl[8]  = '{50, 16'd0,     -1, 16'd0,  25, 1'b1, 1};
        tbl[9]  = '{-1, 16'd0,     -1, 16'd0,  20, 1'b1, 0};
        tbl[10] = '{50, 16'd30,    -1, 16'd0,  20, 1'b1, 1};

        bus.to_pwm_oe = 1'b0;
        bus.to_pwm    = 16'd0;
        rst = 1'b1;
        repeat (3) step();
        check("reset pwm_out", int'(bus.pwm_out), 0);
        check("reset armed", int'(bus.armed), 0);
        check("reset period_start", int'(bus.period_start), 0);
        check("reset cmd_ack", int'(bus.cmd_ack), 0);
        check("reset failsafe", int'(bus.failsafe), 0);
        rst = 1'b0;
        step();

        for (int i = 0; i < 11; i++) begin
            run_period(tbl[i].sa, tbl[i].va, tbl[i].sb, tbl[i].vb, tbl[i].e_hi,
                       tbl[i].e_armed, tbl[i].e_acks, 1'b0, $sformatf("tbl%0d", i));
        end

        // Mid-period reset during a 50-tick pulse.
        for (int p = 0; p < 9; p++) step();
        check("midrst pre pwm_out", int'(bus.pwm_out), 1);
        check("midrst pre period_start", int'(bus.period_start), 0);
        rst = 1'b1;
        step();
        check("midrst pwm_out", int'(bus.pwm_out), 0);
        check("midrst armed", int'(bus.armed), 0);
        check("midrst cmd_ack", int'(bus.cmd_ack), 0);
        rst = 1'b0;
        step();
        model_reset();

        // Randomized periods, including the re-arming sequence.
        for (int i = 0; i < 40; i++) begin
            k  = int'($urandom_range(0, 4));
            sa = -1;
            sb = -1;
            if (k >= 2) sa = ($urandom_range(0, 3) == 0) ? 99 : int'($urandom_range(1, 99));
            if (k == 4) sb = int'($urandom_range(1, 99));
            if (sb == sa) sb = -1;
            va = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'($urandom_range(0, 50));
            vb = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'($urandom_range(0, 50));
            model_run(sa, va, sb, vb, $sformatf("rnd%0d", i));
        end

        // Command then silence: watchdog behaviour when compiled in.
        model_run(50, 16'd30, -1, 16'd0, "wdt cmd");
        run_period(-1, 16'd0, -1, 16'd0, 50, 1'b1, 0, 1'b0, "wdt silent1");
        run_period(-1, 16'd0, -1, 16'd0, 50, 1'b1, 0, 1'b0, "wdt silent2");
        run_period(-1, 16'd0, -1, 16'd0, 50, 1'b1, 0, 1'b0, "wdt silent3");
`ifdef BB_PWM_FAILSAFE_EN
        run_period(40, 16'd10, -1, 16'd0, 20, 1'b1, 1, 1'b1, "wdt tripped");
`else
        run_period(40, 16'd10, -1, 16'd0, 50, 1'b1, 1, 1'b0, "wdt tripped");
`endif
        run_period(-1, 16'd0, -1, 16'd0, 30, 1'b1, 0, 1'b0, "wdt recovered");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
